// File: rtl/layer_sched.sv
// Two-layer image pipeline sequencer: launches the layer-0 engine, routes its beats
// to result memory, then runs the 2x2 stride-2 max-pool over both kernel maps.
module layer_sched #(
  parameter int DW    = 20,
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_ready,
  output logic          o_busy,
  output logic          o_l0_start,
  input  logic          i_l0_valid,
  input  logic [DW-1:0] i_l0_data,
  output logic          o_cwr,
  output logic [AW-1:0] o_caddr_wr,
  output logic [DW-1:0] o_cdata_wr,
  output logic          o_crd,
  output logic [AW-1:0] o_caddr_rd,
  input  logic [DW-1:0] i_cdata_rd,
  output logic [2:0]    o_csel
);
  localparam int LW = $clog2(IMG_W);
  localparam int JW = AW - 2;

  typedef enum logic [2:0] {IDLE, L0, L1_RD, L1_WAIT, L1_WR, DONE} state_t;

  state_t          state_q, state_d;
  logic            par_q, par_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic            kern_q, kern_d;
  logic [JW-1:0]   j_q, j_d;
  logic [1:0]      sub_q, sub_d;
  logic            rvld_q;
  logic [1:0]      ret_q;
  logic [DW-1:0]   acc_q, acc_d;

  logic            busy_q, busy_d, start_q, start_d;
  logic            cwr_q, cwr_d, crd_q, crd_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
  logic [2:0]      csel_q, csel_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      par_q      <= 1'b0;
      pix_q      <= '0;
      kern_q     <= 1'b0;
      j_q        <= '0;
      sub_q      <= '0;
      rvld_q     <= 1'b0;
      ret_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= '0;
    end else begin
      state_q    <= state_d;
      par_q      <= par_d;
      pix_q      <= pix_d;
      kern_q     <= kern_d;
      j_q        <= j_d;
      sub_q      <= sub_d;
      rvld_q     <= crd_q;
      ret_q      <= rvld_q ? ret_q + 2'd1 : ret_q;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      cwr_q      <= cwr_d;
      crd_q      <= crd_d;
      caddr_wr_q <= caddr_wr_d;
      caddr_rd_q <= caddr_rd_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    pix_d   = pix_q;
    kern_d  = kern_q;
    j_d     = j_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: if (i_ready) begin
        state_d = L0;
        par_d   = 1'b0;
        pix_d   = '0;
        kern_d  = 1'b0;
      end
      L0: if (i_l0_valid) begin
        par_d = ~par_q;
        if (par_q) begin
          pix_d = pix_q + AW'(1);
          if (&pix_q) begin
            state_d = L1_RD;
            kern_d  = 1'b0;
            j_d     = '0;
            sub_d   = '0;
          end
        end
      end
      L1_RD: begin
        sub_d = sub_q + 2'd1;
        if (&sub_q) state_d = L1_WAIT;
      end
      L1_WAIT: state_d = L1_WR;
      L1_WR: begin
        j_d     = j_q + JW'(1);
        state_d = L1_RD;
        if (&j_q) begin
          if (kern_q) state_d = DONE;
          else        kern_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands one cycle behind o_crd; the first of each group of four loads the max.
  always_comb begin
    acc_d = acc_q;
    if (rvld_q && (ret_q == 2'd0 || $signed(i_cdata_rd) > $signed(acc_q)))
      acc_d = i_cdata_rd;
  end

  // Outputs are the registered image of what the current state does this cycle.
  always_comb begin
    busy_d     = (state_d != IDLE);
    start_d    = (state_q == IDLE) && i_ready;
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    caddr_wr_d = '0;
    caddr_rd_d = '0;
    cdata_wr_d = '0;
    csel_d     = 3'd0;
    case (state_q)
      L0: if (i_l0_valid) begin
        cwr_d      = 1'b1;
        caddr_wr_d = pix_q;
        cdata_wr_d = i_l0_data;
        csel_d     = par_q ? 3'd2 : 3'd1;
      end
      L1_RD: begin
        crd_d      = 1'b1;
        caddr_rd_d = {j_q[JW-1:LW-1], sub_q[1], j_q[LW-2:0], sub_q[0]};
        csel_d     = kern_q ? 3'd2 : 3'd1;
      end
      L1_WR: begin
        cwr_d      = 1'b1;
        caddr_wr_d = AW'(j_q);
        cdata_wr_d = acc_d;
        csel_d     = kern_q ? 3'd4 : 3'd3;
      end
      default: ;
    endcase
  end

  assign o_busy     = busy_q;
  assign o_l0_start = start_q;
  assign o_cwr      = cwr_q;
  assign o_crd      = crd_q;
  assign o_caddr_wr = caddr_wr_q;
  assign o_caddr_rd = caddr_rd_q;
  assign o_cdata_wr = cdata_wr_q;
  assign o_csel     = csel_q;
endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: start handshake, L0 routing, L1 max-pool timing and abort.
`timescale 1ns/1ps
module tb_layer_sched;
  localparam int DW     = 20;
  localparam int IMG_W  = 64;
  localparam int AW     = 12;
  localparam int HW     = IMG_W / 2;
  localparam int NOUT   = HW * HW;
  localparam int NBEAT  = 2 * IMG_W * IMG_W;
  localparam int L1_CYC = 2 * NOUT * 6;
  localparam int OW     = 7 + AW + AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_l0_valid = 1'b0;
  logic [DW-1:0] i_l0_data = '0;
  logic [DW-1:0] i_cdata_rd = '0;
  logic          o_busy, o_l0_start, o_cwr, o_crd;
  logic [AW-1:0] o_caddr_wr, o_caddr_rd;
  logic [DW-1:0] o_cdata_wr;
  logic [2:0]    o_csel;
  logic [OW-1:0] allo;

  int total = 0;
  int bad   = 0;
  int offs[4] = '{0, 1, IMG_W, IMG_W + 1};

  always #5 clk = ~clk;

  layer_sched #(.DW(DW), .IMG_W(IMG_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .i_ready(i_ready), .o_busy(o_busy), .o_l0_start(o_l0_start),
    .i_l0_valid(i_l0_valid), .i_l0_data(i_l0_data), .o_cwr(o_cwr), .o_caddr_wr(o_caddr_wr),
    .o_cdata_wr(o_cdata_wr), .o_crd(o_crd), .o_caddr_rd(o_caddr_rd), .i_cdata_rd(i_cdata_rd),
    .o_csel(o_csel)
  );

  assign allo = {o_busy, o_l0_start, o_cwr, o_crd, o_csel, o_caddr_wr, o_caddr_rd, o_cdata_wr};

  // Result-memory model: kernel0 map holds a, kernel1 map holds -a; poison when not reading.
  always @(posedge clk) begin
    if (o_crd)
      i_cdata_rd <= (o_csel == 3'd1) ? DW'(o_caddr_rd) : DW'(0) - DW'(o_caddr_rd);
    else
      i_cdata_rd <= 20'h7FFFF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int base(input int j);
    return 2 * (j / HW) * IMG_W + 2 * (j % HW);
  endfunction

  initial begin
    int ph, o, k, j, found;
    logic [DW-1:0] e;

    repeat (5) @(negedge clk);
    chk("rst_outs", 32'(|allo), 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'(|allo), 0);
    end

    // start handshake, then a stray second request while busy
    i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_pulse", o_l0_start, 1);
    @(negedge clk);
    chk("start_once", o_l0_start, 0);
    chk("busy_hold", o_busy, 1);
    repeat (8) @(negedge clk);
    i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_restart", o_l0_start, 0);
      @(negedge clk);
    end

    // L0 routing with periodic idle gaps
    for (int b = 0; b < NBEAT; b++) begin
      i_l0_valid = 1'b1; i_l0_data = DW'(b);
      @(negedge clk);
      i_l0_valid = 1'b0;
      chk("l0_cwr", o_cwr, 1);
      chk("l0_sel", o_csel, (b % 2 == 1) ? 2 : 1);
      chk("l0_addr", o_caddr_wr, b / 2);
      chk("l0_data", o_cdata_wr, b);
      if (b % 5 == 2) begin
        @(negedge clk);
        chk("gap_cwr", o_cwr, 0);
        chk("gap_sel", o_csel, 0);
      end
    end

    // L1: 6-cycle period per output, both kernels, then busy drops
    for (int c = 0; c <= L1_CYC; c++) begin
      @(negedge clk);
      ph = c % 6; o = c / 6; k = o / NOUT; j = o % NOUT;
      if (c == L1_CYC) begin
        chk("busy_fall", o_busy, 0);
        chk("end_quiet", 32'(o_crd | o_cwr), 0);
      end else begin
        chk("busy_l1", o_busy, 1);
        chk("excl", 32'(o_crd & o_cwr), 0);
        chk("rd_strobe", o_crd, ph < 4);
        chk("wr_strobe", o_cwr, ph == 5);
        if (ph < 4) begin
          chk("rd_addr", o_caddr_rd, base(j) + offs[ph]);
          chk("rd_sel", o_csel, 1 + k);
        end else if (ph == 5) begin
          e = (k == 0) ? DW'(base(j) + IMG_W + 1) : DW'(0) - DW'(base(j));
          chk("wr_addr", o_caddr_wr, j);
          chk("wr_sel", o_csel, 3 + k);
          chk("wr_data", o_cdata_wr, e);
        end else begin
          chk("wait_sel", o_csel, 0);
        end
      end
    end
    chk("k0_j0_max", (NOUT > 0) ? 32'(base(0) + IMG_W + 1) : 0, 65);

    // second run, aborted by reset at L1 output j=500
    i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    chk("run2_pulse", o_l0_start, 1);
    for (int b = 0; b < NBEAT; b++) begin
      i_l0_valid = 1'b1; i_l0_data = DW'(b);
      @(negedge clk);
    end
    i_l0_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (o_crd) found = 1;
    end
    chk("run2_l1_seen", found, 1);
    repeat (6 * 500) @(negedge clk);
    chk("abort_at_j500", o_caddr_rd, base(500));
    reset = 1'b0;
    #1;
    chk("abort_outs", 32'(|allo), 0);
    repeat (2) @(negedge clk);
    chk("abort_hold", 32'(|allo), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", 32'(|allo), 0);

    // clean restart from pixel 0
    i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    chk("run3_pulse", o_l0_start, 1);
    for (int b = 0; b < 2; b++) begin
      i_l0_valid = 1'b1; i_l0_data = DW'(100 + b);
      @(negedge clk);
      i_l0_valid = 1'b0;
      chk("run3_cwr", o_cwr, 1);
      chk("run3_sel", o_csel, b + 1);
      chk("run3_addr", o_caddr_wr, 0);
      chk("run3_data", o_cdata_wr, 100 + b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
